// File: rtl/fb_port_arbiter_pkg.sv
// Shared definitions for the frame-buffer port arbiter.
//   fb_state_e : FSM state encoding of the arbiter
//   PIX_NONE   : pix_x/pix_y value meaning "no display request this cycle"
//   FB_WORDS   : pixel count of the default 640x480 frame
//   fb_words() : frame size helper for parameterised instances
package fb_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } fb_state_e;

  localparam logic [9:0] PIX_NONE  = 10'h3FF;
  localparam int         H_RES_DEF = 640;
  localparam int         V_RES_DEF = 480;
  localparam int         FB_WORDS  = H_RES_DEF * V_RES_DEF;

  function automatic int fb_words(input int h_res, input int v_res);
    return h_res * v_res;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO in the vga_clk domain. Holds {addr, data} entries.
// The head entry is presented combinationally on rdata_o.
//   vga_clk  : clock
//   rst_n    : async active-low reset (empties the FIFO)
//   push_i   : write wdata_i at the tail
//   wdata_i  : entry to push
//   pop_i    : drop the head entry
//   rdata_o  : head entry
//   full_o   : DEPTH entries stored
//   empty_o  : no entries stored
// Push and pop in the same cycle are legal when full; the count stays put.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one single-port frame-buffer RAM between the VGA display path and a
// pixel writer. Display reads always win; writer traffic is queued in a small
// FIFO and drained on blanking cycles only. A clear command fills the whole
// buffer with one colour after the queued writes have landed.
//   vga_clk, rst_n      : pixel clock, async active-low reset
//   pix_x_i, pix_y_i    : display request (PIX_NONE = blanking)
//   pix_data_o          : pixel for the previous cycle's request
//   wr_valid_i/ready_o  : writer handshake, wr_addr_i/wr_data_i payload
//   clr_req_i/color_i   : clear pulse and fill colour, clr_busy_o status
//   ram_*               : RAM port (address/we/wdata combinational)
module fb_port_arbiter
  import fb_port_arbiter_pkg::*;
#(
  parameter int H_RES      = H_RES_DEF,
  parameter int V_RES      = V_RES_DEF,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              vga_clk,
  input  logic              rst_n,
  input  logic [9:0]        pix_x_i,
  input  logic [9:0]        pix_y_i,
  output logic [DATA_W-1:0] pix_data_o,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              clr_req_i,
  input  logic [DATA_W-1:0] clr_color_i,
  output logic              clr_busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  localparam int                FB_WORDS_L = fb_words(H_RES, V_RES);
  localparam logic [ADDR_W-1:0] FB_LAST    = ADDR_W'(FB_WORDS_L - 1);
  localparam int                ENTRY_W    = ADDR_W + DATA_W;

  fb_state_e         state_q;
  logic              clr_busy_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [DATA_W-1:0] clr_color_q;

  logic              disp;
  logic [ADDR_W-1:0] disp_addr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_in_range;
  logic              drain_state;

  assign disp      = (pix_x_i != PIX_NONE);
  // Constant multiply by H_RES; synthesis reduces it to shift-add.
  assign disp_addr = ADDR_W'(pix_y_i) * ADDR_W'(H_RES) + ADDR_W'(pix_x_i);

  assign pix_data_o = ram_rdata_i;

  assign head_addr     = fifo_head[ENTRY_W-1:DATA_W];
  assign head_data     = fifo_head[DATA_W-1:0];
  assign head_in_range = (head_addr <= FB_LAST);

  assign drain_state = (state_q == ST_IDLE) || (state_q == ST_DRAIN);
  assign fifo_pop    = rst_n & ~disp & drain_state & ~fifo_empty;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign wr_ready_o = rst_n & (state_q == ST_IDLE) & ~clr_req_i
                    & (~fifo_full | fifo_pop);
  assign fifo_push  = wr_valid_i & wr_ready_o;

  assign clr_busy_o = clr_busy_q;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i ({wr_addr_i, wr_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // RAM port mux. Out-of-range queued writes are popped with we low.
  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_wdata_o = '0;
    if (rst_n) begin
      if (disp) begin
        ram_addr_o = disp_addr;
      end else begin
        case (state_q)
          ST_IDLE, ST_DRAIN: begin
            if (!fifo_empty) begin
              ram_addr_o  = head_addr;
              ram_wdata_o = head_data;
              ram_we_o    = head_in_range;
            end
          end
          ST_CLEAR: begin
            ram_addr_o  = clr_ptr_q;
            ram_wdata_o = clr_color_q;
            ram_we_o    = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clr_busy_q  <= 1'b0;
      clr_ptr_q   <= '0;
      clr_color_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req_i) begin
            clr_color_q <= clr_color_i;
            clr_busy_q  <= 1'b1;
            state_q     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            clr_ptr_q <= '0;
            state_q   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (!disp) begin
            if (clr_ptr_q == FB_LAST) begin
              clr_ptr_q  <= '0;
              clr_busy_q <= 1'b0;
              state_q    <= ST_IDLE;
            end else begin
              clr_ptr_q <= clr_ptr_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter. Uses a reduced 640x8 frame so a full
// clear fits in a short run; the RAM model preloads a pattern while in reset.
module tb_fb_port_arbiter;

  localparam int H_RES = 640;
  localparam int V_RES = 8;
  localparam int FBW   = H_RES * V_RES;

  logic        vga_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [9:0]  pix_x   = 10'h3FF;
  logic [9:0]  pix_y   = 10'h3FF;
  logic [15:0] pix_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [18:0] wr_addr  = '0;
  logic [15:0] wr_data  = '0;
  logic        clr_req  = 1'b0;
  logic [15:0] clr_color = '0;
  logic        clr_busy;
  logic [18:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  fb_port_arbiter #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(19), .DATA_W(16), .FIFO_DEPTH(4)
  ) dut (
    .vga_clk(vga_clk), .rst_n(rst_n),
    .pix_x_i(pix_x), .pix_y_i(pix_y), .pix_data_o(pix_data),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .clr_req_i(clr_req), .clr_color_i(clr_color), .clr_busy_o(clr_busy),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  function automatic logic [15:0] pat(input int i);
    return 16'(i) ^ 16'h5A5A;
  endfunction

  logic [15:0] mem [0:8191];
  always @(posedge vga_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8192; i++) mem[i] <= pat(i);
    end else if (ram_we) begin
      mem[ram_addr[12:0]] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr[12:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic blank();
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_cnt, pre_cnt, bad_seq, we_on_disp, ready_bad;

    // ---- reset state
    wr_valid = 1'b1;
    wr_addr  = 19'd7;
    wr_data  = 16'h7777;
    #2;
    chk("rst_ready", wr_ready, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_busy", clr_busy, 0);
    repeat (3) @(posedge vga_clk);
    #3;
    wr_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", wr_ready, 1);
    chk("post_rst_we", ram_we, 0);

    // ---- display sweep on line 5
    for (int x = 0; x < 640; x++) begin
      cyc();
      pix_x = 10'(x);
      pix_y = 10'd5;
      #1;
      chk("disp_addr", ram_addr, 32'(3200 + x));
      chk("disp_we", ram_we, 0);
      if (x > 0) chk("disp_data", pix_data, pat(3200 + x - 1));
    end
    cyc();
    blank();
    #1;
    chk("disp_data_last", pix_data, pat(3839));

    // ---- three writes during active line
    for (int k = 0; k < 3; k++) begin
      cyc();
      pix_x = 10'(k); pix_y = 10'd1;
      wr_valid = 1'b1;
      wr_addr = 19'(100 + k);
      wr_data = 16'(16'h1111 * (k + 1));
      #1;
      chk("act_ready", wr_ready, 1);
      chk("act_we", ram_we, 0);
    end
    cyc(); wr_valid = 1'b0; pix_x = 10'd3; #1;
    chk("act_hold_we", ram_we, 0);
    cyc(); pix_x = 10'd4; #1;
    chk("act_hold_we2", ram_we, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); blank(); #1;
      chk("act_pop_we", ram_we, 1);
      chk("act_pop_addr", ram_addr, 32'(100 + k));
      chk("act_pop_data", ram_wdata, 32'(16'h1111 * (k + 1)));
    end
    cyc(); #1;
    chk("act_empty_we", ram_we, 0);

    // ---- FIFO full: five back-to-back pushes during display
    for (int k = 0; k < 4; k++) begin
      cyc();
      pix_x = 10'(10 + k); pix_y = 10'd2;
      wr_valid = 1'b1;
      wr_addr = 19'(300 + k);
      wr_data = 16'(16'hA000 + k);
      #1;
      chk("full_push_ready", wr_ready, 1);
    end
    cyc(); pix_x = 10'd14; wr_addr = 19'd304; wr_data = 16'hA004; #1;
    chk("full_ready_low", wr_ready, 0);
    cyc(); pix_x = 10'd15; #1;
    chk("full_ready_low2", wr_ready, 0);
    cyc(); blank(); #1;
    chk("full_bypass_ready", wr_ready, 1);
    chk("full_pop0_we", ram_we, 1);
    chk("full_pop0_addr", ram_addr, 300);
    for (int k = 1; k < 5; k++) begin
      cyc(); wr_valid = 1'b0; #1;
      chk("full_pop_we", ram_we, 1);
      chk("full_pop_addr", ram_addr, 32'(300 + k));
      chk("full_pop_data", ram_wdata, 32'(16'hA000 + k));
    end
    cyc(); #1;
    chk("full_empty_we", ram_we, 0);

    // ---- clear with two writes queued
    cyc(); pix_x = 10'd0; pix_y = 10'd2;
    wr_valid = 1'b1; wr_addr = 19'd500; wr_data = 16'h0BEE; #1;
    chk("clr_push0_ready", wr_ready, 1);
    cyc(); wr_addr = 19'd501; wr_data = 16'h0BEF; #1;
    chk("clr_push1_ready", wr_ready, 1);
    cyc(); wr_valid = 1'b0; clr_req = 1'b1; clr_color = 16'hF800; #1;
    chk("clr_req_ready", wr_ready, 0);
    cyc(); clr_req = 1'b0; clr_color = 16'h0000; #1;
    chk("clr_busy_set", clr_busy, 1);
    chk("clr_busy_ready", wr_ready, 0);
    clr_cnt = 0; pre_cnt = 0; bad_seq = 0; we_on_disp = 0; ready_bad = 0;
    for (int n = 1; n <= 8000; n++) begin
      cyc();
      if (n % 8 == 0) begin pix_x = 10'd1; pix_y = 10'd0; end
      else blank();
      #1;
      if (wr_ready) ready_bad++;
      if (pix_x != 10'h3FF) begin
        if (ram_we) we_on_disp++;
      end else if (ram_we) begin
        if (pre_cnt < 2) begin
          chk("clr_pre_addr", ram_addr, 32'(500 + pre_cnt));
          chk("clr_pre_data", ram_wdata, 32'(16'h0BEE + pre_cnt));
          pre_cnt++;
        end else begin
          if (ram_addr != 19'(clr_cnt) || ram_wdata != 16'hF800) bad_seq++;
          clr_cnt++;
          if (clr_cnt == FBW) begin
            chk("clr_last_busy", clr_busy, 1);
            break;
          end
        end
      end
    end
    chk("clr_pre_count", pre_cnt, 2);
    chk("clr_count", clr_cnt, FBW);
    chk("clr_bad_seq", bad_seq, 0);
    chk("clr_we_on_disp", we_on_disp, 0);
    chk("clr_ready_seen", ready_bad, 0);
    cyc(); blank(); #1;
    chk("clr_done_busy", clr_busy, 0);
    chk("clr_done_ready", wr_ready, 1);
    chk("clr_done_we", ram_we, 0);
    chk("clr_mem_500", mem[500], 16'hF800);
    chk("clr_mem_last", mem[FBW - 1], 16'hF800);

    // ---- clr_req and wr_valid together, then reset mid-clear
    cyc(); clr_req = 1'b1; clr_color = 16'h07E0;
    wr_valid = 1'b1; wr_addr = 19'd600; wr_data = 16'h1234; #1;
    chk("sim_ready", wr_ready, 0);
    cyc(); clr_req = 1'b0; wr_valid = 1'b0; #1;
    chk("sim_busy", clr_busy, 1);
    chk("sim_drain_we", ram_we, 0);
    cyc(); #1;
    chk("sim_first_we", ram_we, 1);
    chk("sim_first_addr", ram_addr, 0);
    chk("sim_first_data", ram_wdata, 16'h07E0);
    repeat (50) cyc();
    chk("mid_clear_busy", clr_busy, 1);
    @(posedge vga_clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", clr_busy, 0);
    chk("arst_we", ram_we, 0);
    repeat (2) @(posedge vga_clk);
    #3;
    rst_n = 1'b1;
    cyc(); #1;
    chk("arst_rel_ready", wr_ready, 1);
    chk("arst_rel_busy", clr_busy, 0);
    chk("arst_rel_we", ram_we, 0);

    // ---- out-of-range write is popped without a RAM write
    cyc(); wr_valid = 1'b1; wr_addr = 19'(FBW); wr_data = 16'h1234; #1;
    chk("oor_ready", wr_ready, 1);
    cyc(); wr_addr = 19'd200; wr_data = 16'h4321; #1;
    chk("oor_drop_we", ram_we, 0);
    chk("oor_pop_addr", ram_addr, 32'(FBW));
    chk("oor_next_ready", wr_ready, 1);
    cyc(); wr_valid = 1'b0; #1;
    chk("oor_next_we", ram_we, 1);
    chk("oor_next_addr", ram_addr, 200);
    chk("oor_next_data", ram_wdata, 16'h4321);
    cyc(); #1;
    chk("oor_mem_untouched", mem[FBW], pat(FBW));
    chk("oor_mem_200", mem[200], 16'h4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
